lm_load_stall_ctrl: RTL and testbench

Stall and sequencing controller for the 5-stage IITB-RISC pipeline. It works alongside the data forwarding unit. Forwarding hides most RAW hazards by selecting bypass data. This block handles the cases forwarding cannot cover:
- Load-use hazards: data is not available until MEM, so the block inserts a stall plus an EX bubble.
- LM/SM multi-register instructions: the block expands one RR-stage instruction into one micro-op per register.
It produces the LMStart and LM_REG signals consumed by the forwarding and register-read logic.

---
 rtl/lm_load_stall_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_lm_load_stall_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lm_load_stall_ctrl.sv
// Purpose : load-use stall and LM/SM micro-op sequencer for the 5-stage IITB-RISC pipeline.
// Latency : load-use costs 1 stall cycle; LM/SM with N listed registers occupies 1 + N cycles.
// Backpres: holds IF/ID/RR through STALL_* and injects an EX bubble; FLUSH aborts same-cycle.
//
// Ports:
//   clk, rst             - rising-edge clock, asynchronous active-high reset
//   FLUSH                - redirect from EX, kills the RR instruction / LM sequence
//   VALID_RR, USE_RA_RR, USE_RB_RR, RA_RR, RB_RR
//                        - RR-stage instruction validity and source operands
//   LM_RR, IMM8_RR       - RR instruction is LM/SM and its register list
//   LD_EX, W_REG_EX, RDest_EX
//                        - EX-stage load flag, write-enable and destination
//   STALL_IF/ID/RR       - hold PC+IF/ID, ID/RR and the RR instruction
//   BUBBLE_EX            - load a NOP into RR/EX
//   LMStart              - [1] sequence active, [0] first micro-op
//   LM_REG               - register index of the current micro-op (0 when idle)
//   LM_DONE              - pulse on the last micro-op
module lm_load_stall_ctrl #(
  parameter int NREG   = 8,
  parameter int RIDX_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FLUSH,
  input  logic              VALID_RR,
  input  logic              USE_RA_RR,
  input  logic              USE_RB_RR,
  input  logic [RIDX_W-1:0] RA_RR,
  input  logic [RIDX_W-1:0] RB_RR,
  input  logic              LM_RR,
  input  logic [NREG-1:0]   IMM8_RR,
  input  logic              LD_EX,
  input  logic              W_REG_EX,
  input  logic [RIDX_W-1:0] RDest_EX,
  output logic              STALL_IF,
  output logic              STALL_ID,
  output logic              STALL_RR,
  output logic              BUBBLE_EX,
  output logic [1:0]        LMStart,
  output logic [RIDX_W-1:0] LM_REG,
  output logic              LM_DONE
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LM_SETUP = 2'd1,
    S_LM_SEQ   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREG-1:0]   mask_q, mask_d;

  // Decoded (pre-reset-gating) outputs.
  logic              stall_if_c;
  logic              stall_id_c;
  logic              stall_rr_c;
  logic              bubble_ex_c;
  logic [1:0]        lm_start_c;
  logic [RIDX_W-1:0] lm_reg_c;
  logic              lm_done_c;

  // Hazard detect and mask helpers.
  logic              haz;
  logic              lm_entry;
  logic [RIDX_W-1:0] low_idx;
  logic [NREG-1:0]   mask_rest;

  // A load in EX cannot forward to RR this cycle; its data first exists in MEM.
  always_comb begin
    haz = VALID_RR & LD_EX & W_REG_EX &
          ((USE_RA_RR & (RA_RR == RDest_EX)) |
           (USE_RB_RR & (RB_RR == RDest_EX)));
  end

  // An empty register list is a no-op and never enters the sequencer.
  always_comb begin
    lm_entry = VALID_RR & LM_RR & (|IMM8_RR);
  end

  // Lowest set bit of the latched list; scanning downward lets the lowest hit win.
  always_comb begin
    low_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_idx = RIDX_W'(i);
      end
    end
  end

  // Mask with its lowest set bit cleared.
  always_comb begin
    mask_rest = mask_q & (mask_q - NREG'(1));
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    stall_if_c  = 1'b0;
    stall_id_c  = 1'b0;
    stall_rr_c  = 1'b0;
    bubble_ex_c = 1'b0;
    lm_start_c  = 2'b00;
    lm_reg_c    = '0;
    lm_done_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (FLUSH) begin
          // Redirect wins: the RR instruction is dead, nothing to stall for.
          state_d = S_IDLE;
        end else if (haz) begin
          // One-cycle penalty; next cycle the load sits in MEM and forwards.
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          stall_rr_c  = 1'b1;
          bubble_ex_c = 1'b1;
        end else if (lm_entry) begin
          // Setup bubble: freeze the front end while the list is latched.
          mask_d      = IMM8_RR;
          state_d     = S_LM_SETUP;
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          stall_rr_c  = 1'b1;
          bubble_ex_c = 1'b1;
        end
      end

      S_LM_SETUP: begin
        if (FLUSH) begin
          state_d = S_IDLE;
          mask_d  = '0;
        end else if (mask_q == '0) begin
          // Unreachable by construction; recover cleanly instead of hanging.
          state_d = S_IDLE;
        end else begin
          lm_start_c = 2'b11;
          lm_reg_c   = low_idx;
          mask_d     = mask_rest;
          if (mask_rest == '0) begin
            lm_done_c = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            state_d    = S_LM_SEQ;
          end
        end
      end

      S_LM_SEQ: begin
        if (FLUSH) begin
          state_d = S_IDLE;
          mask_d  = '0;
        end else if (mask_q == '0) begin
          state_d = S_IDLE;
        end else begin
          lm_start_c = 2'b10;
          lm_reg_c   = low_idx;
          mask_d     = mask_rest;
          if (mask_rest == '0) begin
            lm_done_c = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Outputs are combinational from RR/EX inputs, so reset must also mask them
  // directly; otherwise a hazard seen during reset would still raise stalls.
  always_comb begin
    STALL_IF  = stall_if_c  & ~rst;
    STALL_ID  = stall_id_c  & ~rst;
    STALL_RR  = stall_rr_c  & ~rst;
    BUBBLE_EX = bubble_ex_c & ~rst;
    LMStart   = lm_start_c  & {2{~rst}};
    LM_REG    = lm_reg_c    & {RIDX_W{~rst}};
    LM_DONE   = lm_done_c   & ~rst;
  end

endmodule

// File: tb/tb_lm_load_stall_ctrl.sv
module tb_lm_load_stall_ctrl;

  logic       clk;
  logic       rst;
  logic       FLUSH;
  logic       VALID_RR;
  logic       USE_RA_RR;
  logic       USE_RB_RR;
  logic [2:0] RA_RR;
  logic [2:0] RB_RR;
  logic       LM_RR;
  logic [7:0] IMM8_RR;
  logic       LD_EX;
  logic       W_REG_EX;
  logic [2:0] RDest_EX;
  logic       STALL_IF;
  logic       STALL_ID;
  logic       STALL_RR;
  logic       BUBBLE_EX;
  logic [1:0] LMStart;
  logic [2:0] LM_REG;
  logic       LM_DONE;

  int n_checks = 0;
  int n_pass   = 0;

  // Output vector: {STALL_IF, STALL_ID, STALL_RR, BUBBLE_EX, LMStart[1:0], LM_REG[2:0], LM_DONE}
  logic [9:0] outs;
  assign outs = {STALL_IF, STALL_ID, STALL_RR, BUBBLE_EX, LMStart, LM_REG, LM_DONE};

  localparam logic [9:0] EXP_ZERO  = 10'b0000_00_000_0;
  localparam logic [9:0] EXP_STALL = 10'b1111_00_000_0;

  lm_load_stall_ctrl #(.NREG(8), .RIDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .FLUSH     (FLUSH),
    .VALID_RR  (VALID_RR),
    .USE_RA_RR (USE_RA_RR),
    .USE_RB_RR (USE_RB_RR),
    .RA_RR     (RA_RR),
    .RB_RR     (RB_RR),
    .LM_RR     (LM_RR),
    .IMM8_RR   (IMM8_RR),
    .LD_EX     (LD_EX),
    .W_REG_EX  (W_REG_EX),
    .RDest_EX  (RDest_EX),
    .STALL_IF  (STALL_IF),
    .STALL_ID  (STALL_ID),
    .STALL_RR  (STALL_RR),
    .BUBBLE_EX (BUBBLE_EX),
    .LMStart   (LMStart),
    .LM_REG    (LM_REG),
    .LM_DONE   (LM_DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    FLUSH     = 1'b0;
    VALID_RR  = 1'b0;
    USE_RA_RR = 1'b0;
    USE_RB_RR = 1'b0;
    RA_RR     = 3'd0;
    RB_RR     = 3'd0;
    LM_RR     = 1'b0;
    IMM8_RR   = 8'h00;
    LD_EX     = 1'b0;
    W_REG_EX  = 1'b0;
    RDest_EX  = 3'd0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_ra(input logic [2:0] r);
    clr_in();
    VALID_RR  = 1'b1;
    USE_RA_RR = 1'b1;
    RA_RR     = r;
    LD_EX     = 1'b1;
    W_REG_EX  = 1'b1;
    RDest_EX  = r;
  endtask

  task automatic set_lm(input logic [7:0] list);
    clr_in();
    VALID_RR  = 1'b1;
    LM_RR     = 1'b1;
    IMM8_RR   = list;
    USE_RA_RR = 1'b1;
    RA_RR     = 3'd6;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    #3;
    check("reset_outs", outs, EXP_ZERO);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_reset_idle", outs, EXP_ZERO);

    // Load-use on RA: one stall cycle, then clear once the load leaves EX.
    cyc();
    set_load_ra(3'd3);
    #1 check("ldu_ra", outs, EXP_STALL);
    cyc();
    LD_EX = 1'b0;
    #1 check("ldu_ra_next", outs, EXP_ZERO);

    // Load-use on RB.
    cyc();
    clr_in();
    VALID_RR = 1'b1; USE_RB_RR = 1'b1; RB_RR = 3'd5;
    LD_EX = 1'b1; W_REG_EX = 1'b1; RDest_EX = 3'd5;
    #1 check("ldu_rb", outs, EXP_STALL);

    // No false stalls.
    cyc();
    set_load_ra(3'd3);
    W_REG_EX = 1'b0;
    #1 check("nostall_nowrite", outs, EXP_ZERO);
    cyc();
    clr_in();
    VALID_RR = 1'b1; USE_RA_RR = 1'b1; RA_RR = 3'd1;
    USE_RB_RR = 1'b0; RB_RR = 3'd5;
    LD_EX = 1'b1; W_REG_EX = 1'b1; RDest_EX = 3'd5;
    #1 check("nostall_rb_unused", outs, EXP_ZERO);
    cyc();
    set_load_ra(3'd4);
    VALID_RR = 1'b0;
    #1 check("nostall_invalid", outs, EXP_ZERO);
    cyc();
    set_load_ra(3'd4);
    LD_EX = 1'b0;
    #1 check("nostall_not_load", outs, EXP_ZERO);

    // LM 10100100 -> regs 2, 5, 7. A hazard pattern during the sequence is ignored.
    cyc();
    set_lm(8'b1010_0100);
    #1 check("lm3_entry", outs, EXP_STALL);
    cyc();
    set_load_ra(3'd6);
    #1 check("lm3_setup_r2", outs, 10'b1100_11_010_0);
    cyc();
    #1 check("lm3_seq_r5", outs, 10'b1100_10_101_0);
    cyc();
    clr_in();
    #1 check("lm3_last_r7", outs, 10'b0000_10_111_1);
    cyc();
    #1 check("lm3_idle_after", outs, EXP_ZERO);

    // Single-bit list.
    cyc();
    set_lm(8'b0000_0001);
    #1 check("lm1_entry", outs, EXP_STALL);
    cyc();
    clr_in();
    #1 check("lm1_setup_done", outs, 10'b0000_11_000_1);
    cyc();
    #1 check("lm1_idle_after", outs, EXP_ZERO);

    // Empty list passes through as a no-op.
    cyc();
    set_lm(8'h00);
    #1 check("lm0_nostall", outs, EXP_ZERO);
    cyc();
    #1 check("lm0_still_idle", outs, EXP_ZERO);

    // FLUSH in the second micro-op of 8'hFF.
    cyc();
    set_lm(8'hFF);
    #1 check("lmff_entry", outs, EXP_STALL);
    cyc();
    clr_in();
    #1 check("lmff_setup_r0", outs, 10'b1100_11_000_0);
    cyc();
    FLUSH = 1'b1;
    #1 check("lmff_flush", outs, EXP_ZERO);
    cyc();
    FLUSH = 1'b0;
    #1 check("lmff_idle_after", outs, EXP_ZERO);

    // FLUSH in IDLE suppresses a hazard.
    cyc();
    set_load_ra(3'd2);
    FLUSH = 1'b1;
    #1 check("flush_over_haz", outs, EXP_ZERO);

    // Fresh LM restarts from register 0.
    cyc();
    set_lm(8'hFF);
    #1 check("lmff2_entry", outs, EXP_STALL);
    cyc();
    clr_in();
    #1 check("lmff2_setup_r0", outs, 10'b1100_11_000_0);
    cyc();
    #1 check("lmff2_seq_r1", outs, 10'b1100_10_001_0);

    // Async reset mid-sequence.
    cyc();
    #1 check("lmff2_seq_r2", outs, 10'b1100_10_010_0);
    #1 rst = 1'b1;
    #1 check("rst_mid_lm", outs, EXP_ZERO);
    cyc();
    rst = 1'b0;
    #1 check("rst_mid_lm_idle", outs, EXP_ZERO);
    cyc();
    #1 check("rst_mid_lm_stays_idle", outs, EXP_ZERO);

    // Async reset concurrent with a hazard.
    cyc();
    set_load_ra(3'd7);
    #1 check("haz_before_rst", outs, EXP_STALL);
    #1 rst = 1'b1;
    #1 check("rst_with_haz", outs, EXP_ZERO);
    cyc();
    rst = 1'b0;
    clr_in();
    #1 check("rst_haz_idle", outs, EXP_ZERO);
    cyc();
    set_load_ra(3'd7);
    #1 check("haz_after_rst", outs, EXP_STALL);

    cyc();
    clr_in();
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
